// File: rtl/shift_register_pkg.sv
// Shared helpers for the elastic valid/ready shift register.
package shift_register_pkg;

  // Width of a counter that must hold the values 0..d inclusive.
  function automatic int occ_w(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/srvr_stage.sv
// One stage of the elastic delay line: a valid bit and a data word, advancing
// whenever this stage is empty or the stage downstream accepts.
module srvr_stage #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             acc_nxt,
  input  logic             src_vld,
  input  logic [width-1:0] src_data,
  output logic             acc,
  output logic             vld,
  output logic [width-1:0] data
);

  // An empty stage always accepts, which is what collapses bubbles.
  assign acc = !vld || acc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (flush) begin
      vld  <= 1'b0;
    end else if (acc) begin
      vld <= src_vld;
      if (src_vld) data <= src_data;
    end
  end

endmodule

// File: rtl/shift_register_with_valid_ready.sv
// Elastic width x depth delay line with valid/ready handshake, bubble collapsing
// and a registered occupancy count. Define SRVR_FLUSH_EN to add a synchronous flush.
module shift_register_with_valid_ready
  import shift_register_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [width-1:0]         in_data,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [width-1:0]         out_data,
  output logic [occ_w(depth)-1:0]  occupancy
`ifdef SRVR_FLUSH_EN
  ,
  input  logic                     flush
`endif
);

  localparam int OW = occ_w(depth);

  logic [depth:0]                  acc;
  logic [depth-1:0]                vld;
  logic [depth-1:0][width-1:0]     data;
  logic [depth-1:0]                src_vld;
  logic [depth-1:0][width-1:0]     src_data;
  logic                            flush_q;
  logic                            in_xfer;
  logic                            out_xfer;

`ifdef SRVR_FLUSH_EN
  assign flush_q = flush;
`else
  assign flush_q = 1'b0;
`endif

  // Ready ripples combinationally from the consumer back to the producer.
  assign acc[depth] = out_rdy;

  for (genvar g = 0; g < depth; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign src_vld[g]  = in_vld;
      assign src_data[g] = in_data;
    end else begin : g_body
      assign src_vld[g]  = vld[g-1];
      assign src_data[g] = data[g-1];
    end

    srvr_stage #(.width(width)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush_q),
      .acc_nxt  (acc[g+1]),
      .src_vld  (src_vld[g]),
      .src_data (src_data[g]),
      .acc      (acc[g]),
      .vld      (vld[g]),
      .data     (data[g])
    );
  end

  assign in_rdy   = acc[0] && !flush_q;
  assign out_vld  = vld[depth-1];
  assign out_data = data[depth-1];
  assign in_xfer  = in_vld && in_rdy;
  assign out_xfer = out_vld && out_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else if (flush_q) begin
      occupancy <= '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule
